// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: sweeps an external ALU through sel 0..LAST_SEL on latched operands and captures each result
// Define ALU_SEQ_MISR_EN to compress captured results into a 16-bit MISR signature.
module alu_op_sequencer #(
  parameter int         SETTLE   = 2,
  parameter logic [3:0] LAST_SEL = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  input  logic [12:0] result,
  output logic [7:0]  a,
  output logic [7:0]  b,
  output logic [3:0]  sel,
  output logic        busy,
  output logic        done,
  output logic        res_valid,
  output logic [3:0]  res_sel,
  output logic [12:0] res_data,
  output logic [15:0] signature
);
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE, ST_DONE} state_t;
  state_t state, next;
  logic [3:0] cnt;
  logic accept, capture;
  assign accept  = state == ST_IDLE && start && !abort;
  assign capture = state == ST_CAPTURE && !abort;
  assign busy    = state == ST_SETTLE || state == ST_CAPTURE;
  assign done    = state == ST_DONE;
  always_comb begin
    next = state;
    case (state)
      ST_IDLE:    next = accept ? ST_SETTLE : ST_IDLE;
      ST_SETTLE:  next = abort ? ST_IDLE : (cnt == 4'd0 ? ST_CAPTURE : ST_SETTLE);
      ST_CAPTURE: next = abort ? ST_IDLE : (sel == LAST_SEL ? ST_DONE : ST_SETTLE);
      default:    next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a         <= '0;
      b         <= '0;
      sel       <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_sel   <= '0;
      res_data  <= '0;
    end else begin
      res_valid <= capture;
      if (accept) begin
        a   <= op_a;
        b   <= op_b;
        sel <= '0;
        cnt <= 4'(SETTLE - 1);
      end else if (busy && abort) begin
        sel <= '0;
      end else if (state == ST_SETTLE) begin
        cnt <= cnt - 4'd1;
      end else if (capture) begin
        res_sel  <= sel;
        res_data <= result;
        if (sel != LAST_SEL) begin
          sel <= sel + 4'd1;
          cnt <= 4'(SETTLE - 1);
        end
      end
    end
`ifdef ALU_SEQ_MISR_EN
  logic [15:0] misr_next;
  assign misr_next = {signature[14:0], signature[15] ^ signature[14] ^ signature[12] ^ signature[3]} ^ {3'b000, result};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) signature <= '0;
    else if (accept) signature <= '0;
    else if (capture) signature <= misr_next;
`else
  assign signature = 16'h0000;
`endif
endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter SETTLE, default 2, range 1..15: cycles each sel is held before the result is captured.
REQ-002 Parameter LAST_SEL, default 4'hF: final sel code of a sweep; sweep always starts at 4'h0.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request a sweep; sampled only in IDLE.
REQ-006 abort  input  1  synchronous sweep cancel.
REQ-007 op_a  input  8  operand A, latched on start acceptance.
REQ-008 op_b  input  8  operand B, latched on start acceptance.
REQ-009 result  input  13  ALU result for the currently driven a/b/sel.
REQ-010 a  output  8  registered operand A to the ALU.
REQ-011 b  output  8  registered operand B to the ALU.
REQ-012 sel  output  4  registered opcode to the ALU.
REQ-013 busy  output  1  high in SETTLE and CAPTURE.
REQ-014 done  output  1  one-cycle pulse on sweep completion.
REQ-015 res_valid  output  1  one-cycle pulse per captured result.
REQ-016 res_sel  output  4  opcode of the captured result.
REQ-017 res_data  output  13  captured result.
REQ-018 signature  output  16  result signature (see Configuration).

Function
REQ-019 States SHALL be IDLE, SETTLE, CAPTURE, DONE.
REQ-020 IDLE with start=1 and abort=0: latch a<=op_a, b<=op_b, sel<=0, settle counter<=SETTLE-1, signature<=0, go SETTLE.
REQ-021 SETTLE: decrement counter; at counter 0 go CAPTURE; SETTLE lasts exactly SETTLE cycles.
REQ-022 CAPTURE (one cycle): at the closing edge res_data<=result, res_sel<=sel, res_valid<=1 for the next cycle only.
REQ-023 CAPTURE exit: sel==LAST_SEL -> DONE; else sel<=sel+1, counter<=SETTLE-1, go SETTLE.
REQ-024 Step period SHALL be SETTLE+1 cycles; with defaults a sweep is 48 cycles from start-accept edge to DONE entry.
REQ-025 DONE: done=1 for one cycle, coincident with the last res_valid; then IDLE; start ignored in DONE.
REQ-026 a, b and sel SHALL NOT change between start acceptance and DONE except the sel increment; op_a/op_b changes mid-sweep are ignored.
REQ-027 start outside IDLE SHALL be ignored (not queued).
REQ-028 abort=1 in SETTLE/CAPTURE: next state IDLE, sel<=0, no res_valid from the aborted step, no done; abort has priority over start and capture.
REQ-029 res_data/res_sel/signature SHALL hold their last values in IDLE.
REQ-030 LAST_SEL=0: single-step sweep, done after first capture.

Reset
REQ-031 rst_n low SHALL immediately force IDLE and a=0, b=0, sel=0, busy=0, done=0, res_valid=0, res_sel=0, res_data=0, signature=0, counter=0.
REQ-032 Reset mid-sweep SHALL discard the sweep; first start after release begins a fresh sweep at sel=0.

Configuration
REQ-033 Macro ALU_SEQ_MISR_EN defined: at each capture edge signature<={signature[14:0], signature[15]^signature[14]^signature[12]^signature[3]} ^ {3'b000, result}.
REQ-034 ALU_SEQ_MISR_EN undefined: no MISR logic; signature tied 16'h0000.

Verification
REQ-035 Defaults, op_a=8'h06, op_b=8'h02, start one cycle, behavioral ALU on a/b/sel -> 16 res_valid pulses 3 cycles apart, res_sel 0..15 in order, res_data equal to model, done with 16th pulse, busy high 48 cycles.
REQ-036 start re-asserted and op_a=8'hFF during sweep -> ignored, a stays 8'h06, exactly one done.
REQ-037 abort asserted in sel=5 SETTLE -> next cycle IDLE, busy=0, sel=0, last res_sel=4, no done.
REQ-038 rst_n low during sel=9 CAPTURE -> all outputs zero without a clock edge; new start gives res_sel sequence from 0.
REQ-039 MISR_EN defined, result tied 13'h0000 -> signature 16'h0000 at done; result tied 13'h0001, LAST_SEL=1 -> signature 16'h0003 at done.
REQ-040 SETTLE=1, LAST_SEL=0 -> res_valid and done exactly 2 cycles after start acceptance edge; MISR_EN undefined -> signature 0 throughout.
